// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
//   Per-sample sequencer for the audio-rate NN path. Each rising edge of sample_clk captures N_IN
//   arithmetically right-shifted input channels into a K-deep tap history, pulses the external
//   conv/dense engine, waits (bounded by TIMEOUT) for its result and latches N_OUT left-shifted
//   outputs. Edges that arrive while a frame is in flight are dropped and counted.
//
//   Optional feature macro: SEQ_SATURATE_OUT_EN
//     defined   - scaled outputs clamp to the signed W-bit range
//     undefined - scaled outputs wrap (low W bits of the shifted value)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   sample_clk   sample strobe (synchronous to clk); rising edge starts a frame
//   sample_in    N_IN packed signed inputs, ch c at [c*W +: W]
//   clear_flags  clears overrun, timeout and overrun_cnt (a coincident set wins)
//   eng_start    one-cycle start pulse to the engine
//   eng_taps     tap history, tap k ch c at [(k*N_IN+c)*W +: W], tap 0 newest
//   eng_out      N_OUT packed engine results
//   eng_out_v    engine result valid (only honoured while waiting for the engine)
//   sample_out   latched scaled outputs, same packing as eng_out
//   out_valid    one-cycle pulse when sample_out updates
//   busy         a frame is in flight
//   overrun      sticky: sample edge arrived while busy
//   timeout      sticky: engine did not answer within TIMEOUT cycles
//   overrun_cnt  saturating count of dropped edges
module conv_frame_sequencer #(
  parameter int unsigned W         = 16,
  parameter int unsigned N_IN      = 1,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned K         = 4,
  parameter int unsigned IN_SHIFT  = 2,
  parameter int unsigned OUT_SHIFT = 2,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clk,
  input  logic [N_IN*W-1:0]     sample_in,
  input  logic                  clear_flags,
  output logic                  eng_start,
  output logic [K*N_IN*W-1:0]   eng_taps,
  input  logic [N_OUT*W-1:0]    eng_out,
  input  logic                  eng_out_v,
  output logic [N_OUT*W-1:0]    sample_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout,
  output logic [7:0]            overrun_cnt
);

  localparam int unsigned TapW = N_IN * W;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StShift, StStart, StRun} state_e;

  state_e                state_q, state_d;
  logic                  prev_sample_clk_q;
  logic [K*N_IN*W-1:0]   taps_q, taps_d;
  logic [CntW-1:0]       cnt_q;
  logic [N_OUT*W-1:0]    sample_out_q, scaled;
  logic                  out_valid_q;
  logic                  overrun_q, timeout_q;
  logic [7:0]            overrun_cnt_q;

  logic edge_det, shift_en, latch_en, timeout_hit, drop;

  assign edge_det = sample_clk & ~prev_sample_clk_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (edge_det) state_d = StShift;
      StShift: state_d = StStart;
      StStart: state_d = StRun;
      StRun:   if (eng_out_v || (cnt_q == CntLast)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath enables
  always_comb begin
    eng_start   = (state_q == StStart);
    busy        = (state_q != StIdle);
    shift_en    = (state_q == StShift);
    latch_en    = (state_q == StRun) && eng_out_v;
    timeout_hit = (state_q == StRun) && !eng_out_v && (cnt_q == CntLast);
    // Includes the cycle RUN hands back to IDLE: still busy, so that edge is lost too.
    drop        = edge_det && (state_q != StIdle);
  end

  // Tap history shift: older taps move up one slot, newest scaled inputs enter at tap 0.
  always_comb begin
    taps_d = taps_q;
    for (int k = K - 1; k >= 1; k--) begin
      taps_d[k*TapW +: TapW] = taps_q[(k-1)*TapW +: TapW];
    end
    for (int c = 0; c < N_IN; c++) begin
      taps_d[c*W +: W] = $signed(sample_in[c*W +: W]) >>> IN_SHIFT;
    end
  end

  // Output scaling
`ifdef SEQ_SATURATE_OUT_EN
  localparam int unsigned SW = W + OUT_SHIFT;
  localparam logic signed [SW-1:0] MaxV = {{(OUT_SHIFT+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MinV = ~MaxV;

  logic signed [SW-1:0] wide [N_OUT];

  always_comb begin
    scaled = '0;
    for (int c = 0; c < N_OUT; c++) begin
      wide[c] = SW'($signed(eng_out[c*W +: W])) <<< OUT_SHIFT;
      if (wide[c] > MaxV) begin
        scaled[c*W +: W] = MaxV[W-1:0];
      end else if (wide[c] < MinV) begin
        scaled[c*W +: W] = MinV[W-1:0];
      end else begin
        scaled[c*W +: W] = wide[c][W-1:0];
      end
    end
  end
`else
  always_comb begin
    scaled = '0;
    for (int c = 0; c < N_OUT; c++) begin
      scaled[c*W +: W] = eng_out[c*W +: W] << OUT_SHIFT;
    end
  end
`endif

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      // High so a sample_clk already high at reset release is not taken as an edge.
      prev_sample_clk_q <= 1'b1;
      taps_q            <= '0;
      cnt_q             <= '0;
      sample_out_q      <= '0;
      out_valid_q       <= 1'b0;
      overrun_q         <= 1'b0;
      timeout_q         <= 1'b0;
      overrun_cnt_q     <= '0;
    end else begin
      prev_sample_clk_q <= sample_clk;

      if (shift_en) taps_q <= taps_d;

      if (state_q == StStart) begin
        cnt_q <= '0;
      end else if ((state_q == StRun) && !eng_out_v) begin
        cnt_q <= cnt_q + 1'b1;
      end

      out_valid_q <= latch_en;
      if (latch_en) sample_out_q <= scaled;

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clear_flags) begin
        overrun_q <= 1'b0;
      end

      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end else if (clear_flags) begin
        timeout_q <= 1'b0;
      end

      if (drop) begin
        if (overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 8'd1;
      end else if (clear_flags) begin
        overrun_cnt_q <= '0;
      end
    end
  end

  assign eng_taps    = taps_q;
  assign sample_out  = sample_out_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Testbench for conv_frame_sequencer: directed and randomized frames checked against a
// behavioural model (tap history array, arithmetic scaling, flag bookkeeping).
module tb_conv_frame_sequencer;

  localparam int W         = 16;
  localparam int N_IN      = 2;
  localparam int N_OUT     = 4;
  localparam int K         = 4;
  localparam int IN_SHIFT  = 2;
  localparam int OUT_SHIFT = 2;
  localparam int TIMEOUT   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                sample_clk;
  logic [N_IN*W-1:0]   sample_in;
  logic                clear_flags;
  logic                eng_start;
  logic [K*N_IN*W-1:0] eng_taps;
  logic [N_OUT*W-1:0]  eng_out;
  logic                eng_out_v;
  logic [N_OUT*W-1:0]  sample_out;
  logic                out_valid;
  logic                busy;
  logic                overrun;
  logic                timeout;
  logic [7:0]          overrun_cnt;

  conv_frame_sequencer #(
    .W(W), .N_IN(N_IN), .N_OUT(N_OUT), .K(K),
    .IN_SHIFT(IN_SHIFT), .OUT_SHIFT(OUT_SHIFT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .sample_in(sample_in),
    .clear_flags(clear_flags), .eng_start(eng_start), .eng_taps(eng_taps),
    .eng_out(eng_out), .eng_out_v(eng_out_v), .sample_out(sample_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun), .timeout(timeout),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  int                 mtaps [K][N_IN];
  logic [N_OUT*W-1:0] m_out;
  bit                 m_ovr, m_to;
  int                 m_cnt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int in_scale(input int v);
    int d;
    d = 1 << IN_SHIFT;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);  // floor division
  endfunction

  function automatic logic [W-1:0] out_scale(input logic [W-1:0] x);
    longint v;
    v = longint'($signed(x)) * (longint'(1) << OUT_SHIFT);
`ifdef SEQ_SATURATE_OUT_EN
    if (v > (longint'(1) << (W - 1)) - 1) v = (longint'(1) << (W - 1)) - 1;
    if (v < -(longint'(1) << (W - 1))) v = -(longint'(1) << (W - 1));
`endif
    return v[W-1:0];
  endfunction

  function automatic logic [K*N_IN*W-1:0] pack_taps();
    logic [K*N_IN*W-1:0] r;
    r = '0;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < N_IN; c++)
        r[(k*N_IN+c)*W +: W] = W'(mtaps[k][c]);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < K; k++)
      for (int c = 0; c < N_IN; c++) mtaps[k][c] = 0;
    m_out = '0; m_ovr = 0; m_to = 0; m_cnt = 0;
  endtask

  task automatic model_accept(input logic [N_IN*W-1:0] sin);
    logic [W-1:0] s;
    for (int k = K - 1; k >= 1; k--)
      for (int c = 0; c < N_IN; c++) mtaps[k][c] = mtaps[k-1][c];
    for (int c = 0; c < N_IN; c++) begin
      s = sin[c*W +: W];
      mtaps[0][c] = in_scale(int'($signed(s)));
    end
  endtask

  task automatic model_drop();
    m_ovr = 1;
    if (m_cnt < 255) m_cnt++;
  endtask

  // inject: 0 none, 1 extra edge early in RUN, 2 extra edge together with eng_out_v,
  //         3 extra edge in RUN together with clear_flags
  task automatic run_frame(input logic [N_IN*W-1:0] sin, input logic [N_OUT*W-1:0] eout,
                           input int lat, input int inject);
    @(negedge clk);
    sample_clk = 1'b1; sample_in = sin;
    model_accept(sin);
    @(negedge clk);
    sample_clk = 1'b0;
    check("shift_busy", 128'(busy), 128'(1));
    check("shift_no_start", 128'(eng_start), 128'(0));
    @(negedge clk);
    check("start_pulse", 128'(eng_start), 128'(1));
    check("start_taps", 128'(eng_taps), 128'(pack_taps()));
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      clear_flags = 1'b0;
      if ((inject == 1 || inject == 3) && i == 0 && lat > 1) begin
        sample_clk = 1'b1; sample_in = $urandom;
        if (inject == 3) clear_flags = 1'b1;
        model_drop();
      end else begin
        sample_clk = 1'b0;
      end
    end
    clear_flags = 1'b0;
    check("run_no_start", 128'(eng_start), 128'(0));
    check("run_busy", 128'(busy), 128'(1));
    eng_out_v = 1'b1; eng_out = eout;
    if (inject == 2) begin
      sample_clk = 1'b1;
      model_drop();
    end
    @(negedge clk);
    eng_out_v = 1'b0; sample_clk = 1'b0;
    for (int c = 0; c < N_OUT; c++) m_out[c*W +: W] = out_scale(eout[c*W +: W]);
    check("out_valid", 128'(out_valid), 128'(1));
    check("sample_out", 128'(sample_out), 128'(m_out));
    check("idle_after", 128'(busy), 128'(0));
    check("taps_held", 128'(eng_taps), 128'(pack_taps()));
    check("overrun", 128'(overrun), 128'(m_ovr));
    check("overrun_cnt", 128'(overrun_cnt), 128'(m_cnt));
    check("timeout", 128'(timeout), 128'(m_to));
    @(negedge clk);
    check("out_valid_pulse", 128'(out_valid), 128'(0));
  endtask

  task automatic run_timeout(input logic [N_IN*W-1:0] sin);
    @(negedge clk);
    sample_clk = 1'b1; sample_in = sin;
    model_accept(sin);
    @(negedge clk);
    sample_clk = 1'b0;
    eng_out_v = 1'b1; eng_out = {$urandom, $urandom};  // before RUN: must be ignored
    @(negedge clk);
    check("to_start", 128'(eng_start), 128'(1));
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      eng_out_v = 1'b0;
    end
    check("to_still_busy", 128'(busy), 128'(1));
    check("to_no_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    m_to = 1;
    check("to_idle", 128'(busy), 128'(0));
    check("to_flag", 128'(timeout), 128'(1));
    check("to_no_valid_end", 128'(out_valid), 128'(0));
    check("to_out_held", 128'(sample_out), 128'(m_out));
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    m_ovr = 0; m_to = 0; m_cnt = 0;
    check("clr_overrun", 128'(overrun), 128'(0));
    check("clr_timeout", 128'(timeout), 128'(0));
    check("clr_cnt", 128'(overrun_cnt), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_IN*W-1:0]  sin;
    logic [N_OUT*W-1:0] eout;
    int lat, inj;

    rst = 1'b1; sample_clk = 1'b1; sample_in = '0; clear_flags = 1'b0;
    eng_out = '0; eng_out_v = 1'b0;
    model_reset();

    // Reset with sample_clk held high: no frame may start
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_start", 128'(eng_start), 128'(0));
    check("rst_taps", 128'(eng_taps), 128'(0));
    check("rst_out", 128'(sample_out), 128'(0));
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_flags", 128'({overrun, timeout, overrun_cnt}), 128'(0));
    sample_clk = 1'b0;
    @(negedge clk);

    // 20000 in -> tap 5000; engine 1250 -> 5000 out
    sin = {16'h1234, 16'd20000};
    eout = {16'd0, 16'd0, 16'd0, 16'd1250};
    run_frame(sin, eout, 10, 0);
    check("dir_tap0", 128'(eng_taps[15:0]), 128'(16'd5000));
    check("dir_out0", 128'(sample_out[15:0]), 128'(16'd5000));

    // History: 4000, 8000, 12000, -16000
    run_frame({16'h0001, 16'd4000}, {$urandom, $urandom}, 2, 0);
    run_frame({16'h8000, 16'd8000}, {$urandom, $urandom}, 3, 0);
    run_frame({16'h7FFF, 16'd12000}, {$urandom, $urandom}, 1, 0);
    run_frame({16'hFFFF, 16'hC180}, {$urandom, $urandom}, 4, 0);  // 0xC180 = -16000
    check("hist_tap0", 128'(eng_taps[0*N_IN*W +: W]), 128'(16'hF060));
    check("hist_tap1", 128'(eng_taps[1*N_IN*W +: W]), 128'(16'd3000));
    check("hist_tap2", 128'(eng_taps[2*N_IN*W +: W]), 128'(16'd2000));
    check("hist_tap3", 128'(eng_taps[3*N_IN*W +: W]), 128'(16'd1000));

    // Overrun during RUN, then clear
    run_frame({$urandom}, {$urandom, $urandom}, 5, 1);
    check("ovr_flag", 128'(overrun), 128'(1));
    check("ovr_cnt1", 128'(overrun_cnt), 128'(1));
    pulse_clear();

    // Edge on the same cycle RUN returns to IDLE is also dropped
    run_frame({$urandom}, {$urandom, $urandom}, 3, 2);
    pulse_clear();

    // clear_flags coincident with a new overrun: set wins
    run_frame({$urandom}, {$urandom, $urandom}, 4, 3);

    // Engine silent -> timeout, then a normal frame
    run_timeout({$urandom});
    run_frame({$urandom}, {$urandom, $urandom}, 6, 0);
    pulse_clear();

    // Output scaling boundaries
    run_frame({$urandom}, {16'h0100, 16'hFFFF, 16'hC800, 16'h3000}, 2, 0);
`ifdef SEQ_SATURATE_OUT_EN
    check("scale_pos", 128'(sample_out[15:0]), 128'(16'h7FFF));
    check("scale_neg", 128'(sample_out[31:16]), 128'(16'h8000));
`else
    check("scale_pos", 128'(sample_out[15:0]), 128'(16'hC000));
    check("scale_neg", 128'(sample_out[31:16]), 128'(16'h2000));
`endif
    check("scale_m1", 128'(sample_out[47:32]), 128'(16'hFFFC));
    check("scale_small", 128'(sample_out[63:48]), 128'(16'h0400));

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      sin  = $urandom;
      eout = {$urandom, $urandom};
      lat  = $urandom_range(1, TIMEOUT - 1);
      inj  = $urandom_range(0, 2);
      run_frame(sin, eout, lat, inj);
    end

    // Reset mid-frame: everything returns to reset values, no late out_valid
    @(negedge clk);
    sample_clk = 1'b1; sample_in = $urandom;
    @(negedge clk); sample_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_taps", 128'(eng_taps), 128'(pack_taps()));
    check("mid_rst_out", 128'(sample_out), 128'(m_out));
    check("mid_rst_flags", 128'({overrun, timeout, overrun_cnt}), 128'(0));
    eng_out_v = 1'b1; eng_out = {$urandom, $urandom};
    @(negedge clk);
    eng_out_v = 1'b0;
    check("mid_rst_no_valid", 128'(out_valid), 128'(0));
    check("mid_rst_no_start", 128'(eng_start), 128'(0));

    // A clean frame after reset
    run_frame({$urandom}, {$urandom, $urandom}, 7, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
